// File: rtl/match_score_track.sv
// match_score_track: per-frame maximum tracker for divider line scores.
// Collects LINES scores per frame, keeps the running maximum (earliest index on
// ties), and publishes best score, its index and a threshold match decision.
// Optional feature: define SCORE_SUM_EN to also publish the sum of all frame scores;
// without it score_sum is tied to zero.
module match_score_track #(
    parameter int unsigned   W      = 19,
    parameter int unsigned   LINES  = 16,
    parameter int unsigned   IDXW   = 4,
    parameter logic [W-1:0]  THRESH = W'(256)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 res_rdy,
    input  logic [W-1:0]         pre_score_line,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         best_score,
    output logic [IDXW-1:0]      best_idx,
    output logic                 match,
    output logic [W+IDXW-1:0]    score_sum
);

    localparam int unsigned SW = W + IDXW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDXW-1:0] LAST_CNT = IDXW'(LINES - 1);

    logic [1:0]      state;
    logic [IDXW-1:0] cnt;
    logic [W-1:0]    run_best;
    logic [IDXW-1:0] run_idx;

    logic            take_new;
    logic [W-1:0]    fin_best;
    logic [IDXW-1:0] fin_idx;
    logic            start_evt;
    logic            last_evt;

    // Running-max update candidate and frame start/end events
    always_comb begin
        take_new  = (cnt == '0) || (pre_score_line > run_best);
        fin_best  = take_new ? pre_score_line : run_best;
        fin_idx   = take_new ? cnt : run_idx;
        start_evt = frame_start;
        last_evt  = (state == S_ACC) && !frame_start && res_rdy && (cnt == LAST_CNT);
    end

    assign busy = (state == S_ACC);
    assign done = (state == S_DONE);

    // FSM, running maximum and published results
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            run_best   <= '0;
            run_idx    <= '0;
            best_score <= '0;
            best_idx   <= '0;
            match      <= 1'b0;
        end else if (start_evt) begin
            // Start or restart from any state; a same-cycle score is score #0
            state    <= S_ACC;
            cnt      <= res_rdy ? IDXW'(1) : '0;
            run_best <= res_rdy ? pre_score_line : '0;
            run_idx  <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (res_rdy) begin
                        if (last_evt) begin
                            state      <= S_DONE;
                            cnt        <= '0;
                            run_best   <= '0;
                            run_idx    <= '0;
                            best_score <= fin_best;
                            best_idx   <= fin_idx;
                            match      <= (fin_best >= THRESH);
                        end else begin
                            cnt      <= cnt + IDXW'(1);
                            run_best <= fin_best;
                            run_idx  <= fin_idx;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SCORE_SUM_EN
    logic [SW-1:0] run_sum;

    // Running sum of accepted scores, published together with best_score
    always_ff @(posedge clk) begin
        if (rst) begin
            run_sum   <= '0;
            score_sum <= '0;
        end else if (start_evt) begin
            run_sum <= res_rdy ? SW'(pre_score_line) : '0;
        end else if (state == S_ACC && res_rdy) begin
            if (last_evt) begin
                run_sum   <= '0;
                score_sum <= run_sum + SW'(pre_score_line);
            end else begin
                run_sum <= run_sum + SW'(pre_score_line);
            end
        end
    end
`else
    assign score_sum = '0;
`endif

endmodule
